// File: rtl/router_pkg.sv
// Shared types for the 1x3 router packet-sequencing controller: state encoding,
// port geometry and the per-state strobe decode.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  typedef struct packed {
    logic detect_addr;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic write_enb_reg;
    logic busy;
  } ctrl_t;

  // Strobe pattern presented while the FSM sits in state s.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      DECODE_ADDRESS:     c.detect_addr = 1'b1;
      LOAD_FIRST_DATA:    begin c.lfd_state   = 1'b1; c.busy = 1'b1; end
      LOAD_DATA:          begin c.ld_state    = 1'b1; c.write_enb_reg = 1'b1; end
      LOAD_PARITY:        begin c.write_enb_reg = 1'b1; c.busy = 1'b1; end
      FIFO_FULL_STATE:    begin c.full_state  = 1'b1; c.busy = 1'b1; end
      LOAD_AFTER_FULL:    begin c.laf_state   = 1'b1; c.write_enb_reg = 1'b1; c.busy = 1'b1; end
      WAIT_TILL_EMPTY:    c.busy = 1'b1;
      CHECK_PARITY_ERROR: begin c.rst_int_reg = 1'b1; c.busy = 1'b1; end
      default:            c.detect_addr = 1'b1;
    endcase
    return c;
  endfunction

  // Select the bit of a per-port vector belonging to port address a.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] v,
                                    input logic [ADDR_W-1:0]    a);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit = hit | (v[i] & (a == ADDR_W'(i)));
    end
    return hit;
  endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: decodes the header destination,
// stalls on busy/full FIFOs and schedules parity load and check.
module router_fsm_ctrl
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_vld,
  input  logic [ADDR_W-1:0]    din,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_addr,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    dest_addr
);

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W-1:0]   dest_addr_r;
  logic [ADDR_W-1:0]   dest_next_s;
  ctrl_t               ctrl_r;
  logic                hdr_valid_s;
  logic                sr_hit_s;

  // Next-state and destination-capture logic.
  always_comb begin
    next_state_s = state_r;
    dest_next_s  = dest_addr_r;
    hdr_valid_s  = pkt_vld & (din < ADDR_W'(NUM_PORTS));
    sr_hit_s     = port_bit(soft_reset, dest_addr_r);
    case (state_r)
      DECODE_ADDRESS: begin
        if (hdr_valid_s) begin
          dest_next_s = din;
          if (port_bit(fifo_empty, din)) begin
            next_state_s = LOAD_FIRST_DATA;
          end else begin
            next_state_s = WAIT_TILL_EMPTY;
          end
        end else begin
          next_state_s = DECODE_ADDRESS;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (port_bit(fifo_empty, dest_addr_r)) begin
          next_state_s = LOAD_FIRST_DATA;
        end else begin
          next_state_s = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next_state_s = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          next_state_s = FIFO_FULL_STATE;
        end else if (!pkt_vld) begin
          next_state_s = LOAD_PARITY;
        end else begin
          next_state_s = LOAD_DATA;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          next_state_s = LOAD_AFTER_FULL;
        end else begin
          next_state_s = FIFO_FULL_STATE;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          next_state_s = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          next_state_s = LOAD_PARITY;
        end else begin
          next_state_s = LOAD_DATA;
        end
      end
      LOAD_PARITY: next_state_s = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) begin
          next_state_s = FIFO_FULL_STATE;
        end else begin
          next_state_s = DECODE_ADDRESS;
        end
      end
      default: next_state_s = DECODE_ADDRESS;
    endcase
    // A read timeout on our own port aborts the packet from any active state.
    if ((state_r != DECODE_ADDRESS) && sr_hit_s) begin
      next_state_s = DECODE_ADDRESS;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State, destination and strobe registers; strobes track the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= DECODE_ADDRESS;
      dest_addr_r <= '0;
      ctrl_r      <= decode_state(DECODE_ADDRESS);
    end else begin
      state_r     <= next_state_s;
      dest_addr_r <= dest_next_s;
      ctrl_r      <= decode_state(next_state_s);
    end
  end

  assign detect_addr   = ctrl_r.detect_addr;
  assign lfd_state     = ctrl_r.lfd_state;
  assign ld_state      = ctrl_r.ld_state;
  assign laf_state     = ctrl_r.laf_state;
  assign full_state    = ctrl_r.full_state;
  assign rst_int_reg   = ctrl_r.rst_int_reg;
  assign write_enb_reg = ctrl_r.write_enb_reg;
  assign busy          = ctrl_r.busy;
  assign dest_addr     = dest_addr_r;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Scoreboard bench for router_fsm_ctrl: directed per-cycle vectors push the
// expected strobes/dest_addr; a monitor pops and compares after each edge.
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_vld;
  logic [1:0] din;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [1:0] dest_addr;

  // {detect, lfd, ld, laf, full, rst_int, wen, busy}
  localparam logic [7:0] E_DEC  = 8'b1000_0000;
  localparam logic [7:0] E_LFD  = 8'b0100_0001;
  localparam logic [7:0] E_LD   = 8'b0010_0010;
  localparam logic [7:0] E_LAF  = 8'b0001_0011;
  localparam logic [7:0] E_FULL = 8'b0000_1001;
  localparam logic [7:0] E_CPE  = 8'b0000_0101;
  localparam logic [7:0] E_WTE  = 8'b0000_0001;
  localparam logic [7:0] E_LP   = 8'b0000_0011;

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  router_fsm_ctrl dut (
    .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .din(din), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .detect_addr(detect_addr), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy),
    .dest_addr(dest_addr)
  );

  // Drive one cycle of inputs and record what the DUT must show after the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] d,
                      input logic f, input logic [2:0] e, input logic [2:0] sr,
                      input logic pd, input logic lpv, input logic [7:0] es,
                      input logic [1:0] ed, input string nm);
    @(negedge clk);
    rst = r; pkt_vld = v; din = d; fifo_full = f; fifo_empty = e;
    soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
    exp_q.push_back({es, ed});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Monitor: one observation per rising edge, compared against the scoreboard.
  initial begin
    logic [9:0] act;
    logic [9:0] exp;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, dest_addr};
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got strobes=%b dest=%0d, expected strobes=%b dest=%0d",
                      nm, act[9:2], act[1:0], exp[9:2], exp[1:0]);
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; pkt_vld = 1'b0; din = 2'd0; fifo_full = 1'b0; fifo_empty = 3'b111;
    soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;

    // Reset with noisy inputs
    step(1'b1, 1'b1, 2'd1, 1'b1, 3'b000, 3'b111, 1'b1, 1'b1, E_DEC, 2'd0, "rst_c1");
    step(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, E_DEC, 2'd0, "rst_c2");

    // Normal packet to port 1: header, 3 payload, parity
    step(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd1, "p1_hdr");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1, "p1_ld1");
    step(1'b0, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1, "p1_ld2");
    step(1'b0, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd1, "p1_ld3");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LP,  2'd1, "p1_lp");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, E_CPE, 2'd1, "p1_cpe");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DEC, 2'd1, "p1_dec");

    // Port 2 FIFO not empty: wait 5 cycles, then load
    step(1'b0, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, E_WTE, 2'd2, "wte_1");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, E_WTE, 2'd2, "wte_hold");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd2, "wte_lfd");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd2, "wte_ld");

    // FIFO full mid-payload for 3 cycles, release, resume
    step(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FULL, 2'd2, "full_1");
    step(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FULL, 2'd2, "full_2");
    step(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FULL, 2'd2, "full_3");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LAF,  2'd2, "laf");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,   2'd2, "laf_ld");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LP,   2'd2, "p2_lp");
    step(1'b0, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0, E_CPE,  2'd2, "p2_cpe");
    step(1'b0, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FULL, 2'd2, "cpe_full");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LAF,  2'd2, "cpe_laf");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, E_DEC,  2'd2, "laf_pdone");

    // Invalid header address 3 is ignored
    step(1'b0, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DEC, 2'd2, "bad_addr");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DEC, 2'd2, "idle_novld");

    // Soft reset: other port ignored, own port aborts
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd0, "p0_hdr");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,  2'd0, "p0_ld");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, E_LD,  2'd0, "sr_other");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, E_DEC, 2'd0, "sr_own");

    // Soft reset while waiting for empty
    step(1'b0, 1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, E_WTE, 2'd1, "wte_p1");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b101, 3'b010, 1'b0, 1'b0, E_DEC, 2'd1, "sr_wte");

    // LAF exits to LOAD_PARITY on low_pkt_valid
    step(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD,  2'd1, "p3_hdr");
    step(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LD,   2'd1, "p3_ld");
    step(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, E_FULL, 2'd1, "p3_full");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LAF,  2'd1, "p3_laf");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, E_LP,   2'd1, "laf_lpv");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_CPE,  2'd1, "p3_cpe");
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_DEC,  2'd1, "p3_dec");

    // rst mid-packet beats soft_reset and clears dest_addr
    step(1'b0, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, E_LFD, 2'd2, "p4_hdr");
    step(1'b1, 1'b1, 2'd0, 1'b1, 3'b111, 3'b100, 1'b1, 1'b1, E_DEC, 2'd0, "rst_mid");

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
